// File: rtl/xnor_pkg.sv
// Shared mode encodings and FOLD state type for the XNOR match pipeline.
package xnor_pkg;

  localparam logic [1:0] MODE_XNOR = 2'b00;
  localparam logic [1:0] MODE_XOR  = 2'b01;
  localparam logic [1:0] MODE_FOLD = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fold_state_e;

endpackage

// File: rtl/match_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module match_popcount #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] cnt_c
);

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_c = cnt_c + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/xnor_match_pipe.sv
// Two-stage XNOR/XOR/FOLD match pipeline with valid/ready handshake,
// popcount of the result and an all-match flag.
module xnor_match_pipe
  import xnor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       MODE,
  input  logic             LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             EQ,
  output logic             FOLD_ABORT
);

  fold_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             fold_abort_q, fold_abort_d;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic             s1_xor_q, s1_xor_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eq_q, eq_d;

  logic             s2_adv_c, s1_adv_c, accept_c;
  logic [WIDTH-1:0] xnor_c;
  logic             emit_c, emit_xor_c;
  logic [WIDTH-1:0] emit_y_c;
  logic [CNT_W-1:0] pop_cnt_c;

  // Each stage advances when empty or when its consumer takes the contents.
  assign s2_adv_c = !s2_valid_q || OUT_READY;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign IN_READY = RST_N && s1_adv_c;
  assign accept_c = IN_VALID && IN_READY;
  assign xnor_c   = A ~^ B;

  // FOLD FSM, accumulator and per-beat result selection.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fold_abort_d = 1'b0;
    emit_c       = 1'b0;
    emit_xor_c   = 1'b0;
    emit_y_c     = '0;
    if (accept_c) begin
      if (MODE == MODE_FOLD) begin
        if (state_q == IDLE) begin
          if (LAST) begin
            emit_c   = 1'b1;
            emit_y_c = xnor_c;
          end else begin
            acc_d   = xnor_c;
            state_d = ACCUM;
          end
        end else begin
          if (LAST) begin
            emit_c   = 1'b1;
            emit_y_c = acc_q ~^ xnor_c;
            acc_d    = '0;
            state_d  = IDLE;
          end else begin
            acc_d = acc_q ~^ xnor_c;
          end
        end
      end else begin
        // A non-FOLD beat mid-burst abandons the accumulation.
        if (state_q == ACCUM) begin
          fold_abort_d = 1'b1;
          acc_d        = '0;
          state_d      = IDLE;
        end
        emit_c     = 1'b1;
        emit_xor_c = (MODE == MODE_XOR);
        emit_y_c   = emit_xor_c ? (A ^ B) : xnor_c;
      end
    end
  end

  match_popcount #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_popcount (
    .vec  (s1_y_q),
    .cnt_c(pop_cnt_c)
  );

  // Pipeline stage next-state; data only reloads when a valid beat moves in.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    s1_xor_d   = s1_xor_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    eq_d       = eq_q;
    if (s1_adv_c) begin
      s1_valid_d = emit_c;
      if (emit_c) begin
        s1_y_d   = emit_y_c;
        s1_xor_d = emit_xor_c;
      end
    end
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d   = s1_y_q;
        cnt_d = pop_cnt_c;
        eq_d  = s1_xor_q ? (s1_y_q == '0) : (s1_y_q == '1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      fold_abort_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_y_q       <= '0;
      s1_xor_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      y_q          <= '0;
      cnt_q        <= '0;
      eq_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fold_abort_q <= fold_abort_d;
      s1_valid_q   <= s1_valid_d;
      s1_y_q       <= s1_y_d;
      s1_xor_q     <= s1_xor_d;
      s2_valid_q   <= s2_valid_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      eq_q         <= eq_d;
    end
  end

  assign OUT_VALID  = s2_valid_q;
  assign Y          = y_q;
  assign MATCH_CNT  = cnt_q;
  assign EQ         = eq_q;
  assign FOLD_ABORT = fold_abort_q;

endmodule
